// File: rtl/dbg_bus_router.sv
// Single-outstanding debug transaction router: decodes the segment field of a host
// request, runs a req/ack handshake with one target and returns data/err with a timeout.
module dbg_bus_router #(
    parameter int Addr_width     = 14,
    parameter int Data_width     = 8,
    parameter int Timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [Addr_width-1:0] req_addr,
    input  logic                  req_write,
    input  logic [Data_width-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [Data_width-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [Addr_width-3:0] tgt_addr,
    output logic                  tgt_write,
    output logic [Data_width-1:0] tgt_wdata,
    output logic                  ctl_req,
    output logic                  rom_req,
    output logic                  ram_req,
    input  logic                  ctl_ack,
    input  logic                  rom_ack,
    input  logic                  ram_ack,
    input  logic [Data_width-1:0] ctl_rdata,
    input  logic [Data_width-1:0] rom_rdata,
    input  logic [Data_width-1:0] ram_rdata
);
    localparam int Cnt_width = $clog2(Timeout_cycles + 1);
    localparam logic [Cnt_width-1:0] Cnt_last = Cnt_width'(Timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q, state_d;
    logic [Cnt_width-1:0]  cnt_q, cnt_d;
    logic [2:0]            req_q, req_d;        // one-hot {ram, rom, ctl}
    logic [Addr_width-3:0] tgt_addr_q, tgt_addr_d;
    logic                  tgt_write_q, tgt_write_d;
    logic [Data_width-1:0] tgt_wdata_q, tgt_wdata_d;
    logic [Data_width-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [1:0]            seg;
    logic [2:0]            ack_vec;
    logic [Data_width-1:0] sel_rdata;

    assign seg     = req_addr[Addr_width-1:Addr_width-2];
    assign ack_vec = {ram_ack, rom_ack, ctl_ack};

    // req_q is one-hot, so an AND-OR mux selects the active target's data.
    assign sel_rdata = ({Data_width{req_q[0]}} & ctl_rdata)
                     | ({Data_width{req_q[1]}} & rom_rdata)
                     | ({Data_width{req_q[2]}} & ram_rdata);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        tgt_addr_d  = tgt_addr_q;
        tgt_write_d = tgt_write_q;
        tgt_wdata_d = tgt_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tgt_addr_d  = req_addr[Addr_width-3:0];
                    tgt_write_d = req_write;
                    tgt_wdata_d = req_wdata;
                    cnt_d       = '0;
                    if (seg == 2'd3) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ISSUE;
                        req_d   = 3'b001 << seg;
                    end
                end
            end
            ISSUE: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if ((req_q & ack_vec) != 3'b000) begin
                    state_d     = RESP;
                    req_d       = 3'b000;
                    rsp_rdata_d = tgt_write_q ? '0 : sel_rdata;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q >= Cnt_last) begin
                    state_d     = RESP;
                    req_d       = 3'b000;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 3'b000;
            tgt_addr_q  <= '0;
            tgt_write_q <= 1'b0;
            tgt_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            tgt_addr_q  <= tgt_addr_d;
            tgt_write_q <= tgt_write_d;
            tgt_wdata_q <= tgt_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign tgt_addr  = tgt_addr_q;
    assign tgt_write = tgt_write_q;
    assign tgt_wdata = tgt_wdata_q;
    assign ctl_req   = req_q[0];
    assign rom_req   = req_q[1];
    assign ram_req   = req_q[2];
endmodule

// File: tb/tb_dbg_bus_router.sv
// Self-checking bench for dbg_bus_router: directed scenarios plus random transactions
// checked against a per-transaction outcome model (latency, req length, data, err).
module tb_dbg_bus_router;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [13:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [11:0] tgt_addr;
    logic        tgt_write;
    logic [7:0]  tgt_wdata;
    logic        ctl_req, rom_req, ram_req;
    logic        ctl_ack = 1'b0, rom_ack = 1'b0, ram_ack = 1'b0;
    logic [7:0]  ctl_rdata = '0, rom_rdata = '0, ram_rdata = '0;
    logic [2:0]  req_vec;

    int checks = 0;
    int errors = 0;

    assign req_vec = {ram_req, rom_req, ctl_req};

    always #5 clk = ~clk;

    dbg_bus_router #(.Addr_width(14), .Data_width(8), .Timeout_cycles(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .tgt_addr(tgt_addr), .tgt_write(tgt_write), .tgt_wdata(tgt_wdata),
        .ctl_req(ctl_req), .rom_req(rom_req), .ram_req(ram_req),
        .ctl_ack(ctl_ack), .rom_ack(rom_ack), .ram_ack(ram_ack),
        .ctl_rdata(ctl_rdata), .rom_rdata(rom_rdata), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_acks(input logic [2:0] a);
        {ram_ack, rom_ack, ctl_ack} = a;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_reqs"}, req_vec, 0);
        chk({tag, "_tgt_addr"}, tgt_addr, 0);
        chk({tag, "_tgt_write"}, tgt_write, 0);
        chk({tag, "_tgt_wdata"}, tgt_wdata, 0);
    endtask

    // One host transaction. d = req-high cycle in which the target acks (d > T: never acks
    // in time), hold = cycles rsp_ready is held low, late = ack the target again in RESP.
    task automatic txn(input logic [13:0] addr, input logic wr, input logic [7:0] wd,
                       input logic [7:0] rd, input int d, input int hold, input bit late);
        logic [1:0] seg;
        logic [2:0] sel;
        bit         rsvd;
        int         exp_cycles;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         cyc;
        seg        = addr[13:12];
        rsvd       = (seg == 2'd3);
        sel        = rsvd ? 3'b000 : (3'b001 << seg);
        exp_cycles = rsvd ? 0 : ((d <= T) ? d : T);
        exp_err    = rsvd || (d > T);
        exp_rd     = (exp_err || wr) ? 8'h00 : rd;

        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 14'($urandom); req_write = 1'($urandom); req_wdata = 8'($urandom);

        cyc = 0;
        while (req_vec != 3'b000 && cyc < 40) begin
            cyc++;
            chk("req_onehot", req_vec, sel);
            chk("issue_tgt_addr", tgt_addr, addr[11:0]);
            chk("issue_tgt_write", tgt_write, wr);
            chk("issue_tgt_wdata", tgt_wdata, wd);
            chk("issue_req_ready", req_ready, 0);
            chk("issue_rsp_valid", rsp_valid, 0);
            ctl_rdata = 8'($urandom); rom_rdata = 8'($urandom); ram_rdata = 8'($urandom);
            case (seg)
                2'd0: ctl_rdata = rd;
                2'd1: rom_rdata = rd;
                default: ram_rdata = rd;
            endcase
            set_acks(((cyc == d) ? sel : 3'b000) | (3'($urandom) & ~sel));
            @(negedge clk);
        end
        chk("req_cycles", cyc, exp_cycles);

        for (int j = 1; j <= hold + 1; j++) begin
            if (j > 1) @(negedge clk);
            chk("resp_valid", rsp_valid, 1);
            chk("resp_req_ready", req_ready, 0);
            chk("resp_rdata", rsp_rdata, exp_rd);
            chk("resp_err", rsp_err, exp_err);
            chk("resp_no_req", req_vec, 0);
            chk("resp_tgt_addr", tgt_addr, addr[11:0]);
            if (late && j == 2) set_acks(sel);
            else set_acks(3'($urandom));
            rsp_ready = (j == hold + 1);
        end
        @(negedge clk);
        set_acks(3'b111);
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("done_no_req", req_vec, 0);
        @(negedge clk);
        set_acks(3'b000);
        chk("idle_ack_rsp_valid", rsp_valid, 0);
        chk("idle_ack_no_req", req_vec, 0);
        $display("txn addr=%04h wr=%0d wd=%02h d=%0d hold=%0d -> rdata=%02h err=%0d req_cycles=%0d",
                 addr, wr, wd, d, hold, exp_rd, exp_err, cyc);
    endtask

    initial begin
        // Reset state, both while asserted and after release.
        repeat (3) @(negedge clk);
        chk_reset_values("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values("after_reset");

        // CTL read, ack in the 2nd req cycle.
        txn(14'h0004, 1'b0, 8'h00, 8'h3A, 2, 0, 1'b0);
        // RAM write, immediate ack.
        txn(14'h2123, 1'b1, 8'h5C, 8'hA7, 1, 0, 1'b0);
        // RSVD read: error, no target touched.
        txn(14'h3000, 1'b0, 8'h11, 8'h99, 1, 0, 1'b0);
        // ROM timeout, late ack during the held response.
        txn(14'h1010, 1'b0, 8'h00, 8'h6E, 99, 3, 1'b1);
        // ROM ack in the final allowed cycle.
        txn(14'h1010, 1'b0, 8'h00, 8'h6E, T, 0, 1'b0);
        // CTL with stray acks from others, then 5 cycles of backpressure.
        txn(14'h0FFF, 1'b0, 8'h00, 8'hC3, 3, 5, 1'b0);

        // Reset mid-ISSUE abandons the transaction.
        req_valid = 1'b1; req_addr = 14'h0ABC; req_write = 1'b1; req_wdata = 8'h42;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_case_ctl_req", ctl_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("mid_issue_reset");
        rst = 1'b0;
        set_acks(3'b001);
        @(negedge clk);
        set_acks(3'b000);
        chk_reset_values("post_abandon");
        txn(14'h2456, 1'b0, 8'h00, 8'h81, 2, 1, 1'b0);

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            int d;
            int h;
            d = $urandom_range(1, 6);
            h = $urandom_range(0, 3);
            txn(14'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), d, h, (d > T) && (h >= 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbg_bus_router.md
# dbg_bus_router

Single-master, single-outstanding router for the 14-bit debug address space. Accepts one host debug transaction at a time, decodes the 2-bit segment field, and drives a req/ack handshake to the CTL, ROM or RAM target with the 12-bit segment offset. It returns read data and an error flag to the host, and protects the host from hung targets with a timeout. Sits between the host debug bridge and the per-segment debug slaves.

## Interface
- `Addr_width`, 14: debug address width; bits [13:12] are the segment (0 CTL, 1 ROM, 2 RAM, 3 RSVD) and bits [11:0] are the offset.
- `Data_width`, 8: debug data width.
- `Timeout_cycles`, 255: maximum cycles a target request stays asserted without ack. Must be ≥1.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1; `req_ready` out 1: host request handshake.
- `req_addr` in 14; `req_write` in 1; `req_wdata` in Data_width: request payload.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_rdata` out Data_width; `rsp_err` out 1: response payload.
- `tgt_addr` out 12; `tgt_write` out 1; `tgt_wdata` out Data_width: shared target payload, registered.
- `ctl_req`, `rom_req`, `ram_req` out 1 each: per-target request, at most one high.
- `ctl_ack`, `rom_ack`, `ram_ack` in 1 each: per-target ack.
- `ctl_rdata`, `rom_rdata`, `ram_rdata` in Data_width each: read data, valid with ack.

## Operation
- FSM states are IDLE, ISSUE, RESP. `req_ready` = (state==IDLE). `rsp_valid` = (state==RESP).
- **IDLE:**
  - On `req_valid`, latch addr, write and wdata into the `tgt_*` registers and clear the timeout counter.
  - If seg==RSVD: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No target is touched.
  - Otherwise: go to ISSUE and set the selected `*_req`=1.
- **ISSUE:** the selected `*_req` is held high and the payload is held stable.
  - Ack from the selected target: drop `*_req`, capture `rsp_rdata` (the target rdata on a read, 0 on a write), set `rsp_err`=0, go to RESP.
  - Acks from non-selected targets are ignored.
  - Each ISSUE cycle without ack increments the counter.
  - If the counter reaches `Timeout_cycles` (the request was high for `Timeout_cycles` cycles) with no ack: drop `*_req`, set `rsp_rdata`=0 and `rsp_err`=1, go to RESP.
  - An ack in the final cycle wins over the timeout.
- **RESP:** `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1, then go to IDLE. A new request cannot be accepted in the same cycle as response completion.
- An ack arriving after a timeout, or while in IDLE or RESP, is ignored. Targets must tolerate their req dropping without ack.
- The counter is `$clog2(Timeout_cycles+1)` bits, saturating-safe, and is cleared on every accept.

## Timing
- Reset values while `rst`=1 and after: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all `*_req`=0, `tgt_addr`=0, `tgt_write`=0, `tgt_wdata`=0.
- Reset in ISSUE or RESP abandons the transaction: req drops the cycle after `rst` is sampled, and no response is issued.
- Accept at cycle N → `*_req` high at N+1. Ack sampled at N+k (k≥1) → `*_req` low and `rsp_valid` high at N+k+1.
- The minimum CTL/ROM/RAM transaction is 3 cycles with an immediate `rsp_ready`.
- RSVD: accept at N → `rsp_valid` at N+1.
- Timeout: `*_req` is high for cycles N+1 through N+`Timeout_cycles`, then `rsp_valid` with err at N+`Timeout_cycles`+1.
- Outputs are registered. `req_ready` and `rsp_valid` are decoded from the state register only, with no combinational path from inputs.

## Test plan
- **CTL read:** read 0x0004, `ctl_ack` 2 cycles after req with `ctl_rdata`=0x3A → `ctl_req` high 2 cycles, `tgt_addr`=0x004, `rsp_rdata`=0x3A, `rsp_err`=0, no other req.
- **RAM write:** write 0x2123 with wdata 0x5C and immediate `ram_ack` → `ram_req` high 1 cycle with `tgt_addr`=0x123, `tgt_write`=1, `tgt_wdata`=0x5C; response `rsp_rdata`=0, `rsp_err`=0.
- **RSVD access:** read 0x3000 → `rsp_valid` one cycle after accept with `rsp_err`=1, and no `*_req` ever asserts.
- **Timeout:** `Timeout_cycles`=4, ROM read 0x1010, no ack → `rom_req` high exactly 4 cycles, then `rsp_err`=1, `rsp_rdata`=0. A `rom_ack` injected 2 cycles later is ignored.
- **Ack at timeout boundary and stray ack:** ack in the 4th cycle (`Timeout_cycles`=4) → success, `rsp_err`=0. `rom_ack` during a CTL transaction is ignored.
- **Backpressure and reset:** hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, data and err stable and `req_ready`=0. Separately, assert `rst` mid-ISSUE → req drops next cycle, all outputs at reset values, and the next request completes normally.
